// File: rtl/cpu_pkg.sv
// Shared decode-stage constants and the interrupt sequencer state encoding.
package cpu_pkg;
  localparam logic [5:0] OP_CALL = 6'b100101;
  localparam logic [5:0] OP_RET  = 6'b100110;
  localparam logic [5:0] OP_RETI = 6'b100111;
  localparam logic [5:0] OP_LDM  = 6'b010010;

  localparam logic [1:0] NO_INTERRUPT = 2'b00;
  localparam logic [1:0] PUSH_FLAGS   = 2'b01;
  localparam logic [1:0] PUSH_1       = 2'b10;

  localparam logic [2:0] RETI_IDLE = 3'd0;
  localparam logic [2:0] NOP2_RETI = 3'd5;

  typedef enum logic [2:0] {IDLE, ARM, FIRE, WAIT_PUSH, SERVICE} seq_state_e;

  // Opcodes that start or continue a multi-cycle sequence in decode.
  function automatic logic is_unsafe_op(input logic [5:0] op);
    return (op == OP_CALL) || (op == OP_RET) || (op == OP_RETI) || (op == OP_LDM);
  endfunction
endpackage

// File: rtl/interrupt_sequencer_if.sv
// Control-unit side of the interrupt sequencer: decode status in, interrupt request out.
interface interrupt_sequencer_if #(parameter int PEND_W = 2);
  logic [5:0]        opcode;
  logic [1:0]        inter_state;
  logic [2:0]        ret_state;
  logic [2:0]        reti_state;
  logic              inst_before_call;
  logic              flush;
  logic              interrupt;
  logic              int_busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ack_err;

  modport master (
    output opcode, inter_state, ret_state, reti_state, inst_before_call, flush,
    input  interrupt, int_busy, pend_cnt, ack_err
  );
  modport slave (
    input  opcode, inter_state, ret_state, reti_state, inst_before_call, flush,
    output interrupt, int_busy, pend_cnt, ack_err
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// Queues external interrupt edges, waits for a safe decode slot, fires a one-cycle
// interrupt and tracks the push sequence and handler until RETI completes (no nesting).
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic int_req,
  interrupt_sequencer_if.slave bus
);
  localparam int              TO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  seq_state_e        state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W:0]   pend_sum;
  logic [TO_W-1:0]   to_q, to_d;
  logic              err_q;
  logic              req_edge, safe, timeout, fire;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (int_req),
    .pulse (req_edge)
  );

  assign safe = (bus.inter_state == NO_INTERRUPT) && (bus.ret_state == 3'd0) &&
                (bus.reti_state == RETI_IDLE) && !bus.inst_before_call &&
                !bus.flush && !is_unsafe_op(bus.opcode);

  assign fire = (state_q == FIRE);

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:      if (pend_q != '0) state_d = ARM;
      ARM:       if (safe) state_d = FIRE;
      FIRE: begin
        to_d    = '0;
        state_d = WAIT_PUSH;
      end
      WAIT_PUSH: begin
        if (bus.inter_state == PUSH_1) begin
          state_d = SERVICE;
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          // Control unit never took the interrupt: hand the request back to the queue.
          timeout = 1'b1;
          state_d = ARM;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      SERVICE:   if (bus.reti_state == NOP2_RETI) state_d = (pend_q != '0) ? ARM : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Decrement/restore and new edge combine first, then clamp, so a full queue stays full.
  assign pend_sum = {1'b0, pend_q} - {{PEND_W{1'b0}}, fire}
                  + {{PEND_W{1'b0}}, timeout} + {{PEND_W{1'b0}}, req_edge};
  assign pend_d   = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.interrupt = fire;
  assign bus.int_busy  = (state_q == FIRE) || (state_q == WAIT_PUSH) || (state_q == SERVICE);
  assign bus.pend_cnt  = pend_q;
  assign bus.ack_err   = err_q;
endmodule
